gate_truth_table_checker: RTL

- Sequential self-test stage placed around a 2-input-style combinational gate-under-test, such as a mux-built OR.
- Upstream role: drives every input combination into the gate.
- Downstream role: samples the gate's output and compares it with an expected truth table.
- Reports a per-vector fail map, an error count and an overall pass flag through a start/busy/done handshake.

---
 rtl/gate_truth_table_checker_pkg.sv | 27 ++
 rtl/gate_truth_table_checker_if.sv | 60 ++++++
 rtl/gate_truth_table_checker_settle_counter.sv | 37 +++
 rtl/gate_truth_table_checker.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/gate_truth_table_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_check_pkg
// Description : Shared types and helpers for the gate truth-table checker:
//               FSM state encoding, err_count width helper and the default
//               OR truth table.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_check_pkg;

    // Checker FSM states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Truth table of a 2-input OR: only vector 0 yields 0.
    localparam logic [3:0] C_OR_TABLE = 4'b1110;

    // err_count must be able to hold every vector failing (0 .. 2**n_in).
    function automatic int err_width(input int n_in);
        return $clog2((2 ** n_in) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_truth_table_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : gate_truth_table_checker_if
// Description : Bundles the run handshake, the gate stimulus/response pair
//               and the result outputs of the checker. The optional fail_idx
//               signal exists only when GATE_CHECK_STOP_ON_FAIL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface gate_truth_table_checker_if #(
    parameter int N_IN = 2
);
    import gate_check_pkg::*;

    localparam int c_nv = 2 ** N_IN;
    localparam int c_ew = err_width(N_IN);

    logic              start;
    logic [N_IN-1:0]   dut_in;
    logic              dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [c_nv-1:0]   fail_vec;
    logic [c_ew-1:0]   err_count;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    logic [N_IN-1:0]   fail_idx;
`endif

    // Requester side: issues start, models the gate, reads results.
    modport master (
        output start,
        input  dut_in,
        output dut_out,
        input  busy,
        input  done,
        input  pass,
        input  fail_vec,
        input  err_count
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        , input fail_idx
`endif
    );

    // Checker side.
    modport slave (
        input  start,
        output dut_in,
        input  dut_out,
        output busy,
        output done,
        output pass,
        output fail_vec,
        output err_count
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        , output fail_idx
`endif
    );

endinterface
`default_nettype wire

// File: rtl/gate_truth_table_checker_settle_counter.sv
`default_nettype none
// ============================================================================
// Module      : settle_counter
// Description : Loadable down-counter that stops at zero and flags terminal
//               count. Times how long each stimulus vector is held.
// Revision    : 1.0 - initial release
// ============================================================================
module settle_counter #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] load_val,
    output logic                  tc
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;

    // Load has priority; otherwise count down while enabled, holding at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    assign tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/gate_truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_truth_table_checker
// Description : Self-test stage for a small combinational gate. Walks every
//               input vector, holds each for SETTLE cycles, samples the gate
//               output and compares it against EXPECTED. Reports a per-vector
//               fail map, a mismatch count and a pass flag.
//               Optional macro GATE_CHECK_STOP_ON_FAIL_EN: end the run at the
//               first mismatch and report its index on fail_idx.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_truth_table_checker
    import gate_check_pkg::*;
#(
    parameter int                    N_IN     = 2,
    parameter int                    SETTLE   = 2,
    parameter logic [(2**N_IN)-1:0]  EXPECTED = C_OR_TABLE
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    gate_truth_table_checker_if.slave bus
);

    localparam int                c_nv       = 2 ** N_IN;
    localparam int                c_ew       = err_width(N_IN);
    localparam int                c_cw       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_cw-1:0]   c_reload   = c_cw'(SETTLE - 1);
    localparam logic [c_ew-1:0]   c_err_max  = c_ew'(c_nv);
    localparam logic [c_ew-1:0]   c_err_one  = c_ew'(1);
    localparam logic [N_IN-1:0]   c_idx_one  = N_IN'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [N_IN-1:0]    r_idx;
    logic [c_nv-1:0]    r_fail_vec;
    logic [c_ew-1:0]    r_err_count;
    logic               r_pass;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    logic [N_IN-1:0]    r_fail_idx;
`endif

    logic               w_accept;
    logic               w_tc;
    logic               w_sample;
    logic               w_mismatch;
    logic               w_last;
    logic               w_finish;
    logic               w_load;
    logic               w_busy;
    logic               w_done;
    logic [N_IN-1:0]    w_dut_in;

    // Run control strobes. A sample happens on the last hold cycle of a vector.
    assign w_accept   = (r_state == ST_IDLE) && bus.start;
    assign w_sample   = (r_state == ST_SETTLE) && w_tc;
    assign w_mismatch = (bus.dut_out != EXPECTED[r_idx]);
    assign w_last     = &r_idx;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    assign w_finish   = w_sample && (w_last || w_mismatch);
`else
    assign w_finish   = w_sample && w_last;
`endif
    // Reload the hold timer at run start and when advancing to the next vector.
    assign w_load     = w_accept || (w_sample && !w_finish);

    settle_counter #(
        .WIDTH (c_cw)
    ) u_settle_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .en       (r_state == ST_SETTLE),
        .load_val (c_reload),
        .tc       (w_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.start) w_state_next = ST_SETTLE;
            ST_SETTLE: if (w_finish)  w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs; stimulus is parked at 0 outside a run.
    always_comb begin
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_dut_in = '0;
        case (r_state)
            ST_SETTLE: begin
                w_busy   = 1'b1;
                w_dut_in = r_idx;
            end
            ST_DONE:   w_done = 1'b1;
            default:   ;
        endcase
    end

    // Vector index: cleared on start, advanced after each non-final sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
        end else if (w_sample && !w_finish) begin
            r_idx <= r_idx + c_idx_one;
        end
    end

    // Result registers: cleared on an accepted start, updated at each sample,
    // pass resolved on the edge that enters DONE (including a final mismatch).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_vec  <= '0;
            r_err_count <= '0;
            r_pass      <= 1'b0;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
            r_fail_idx  <= '0;
`endif
        end else if (w_accept) begin
            r_fail_vec  <= '0;
            r_err_count <= '0;
            r_pass      <= 1'b0;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
            r_fail_idx  <= '0;
`endif
        end else if (w_sample) begin
            if (w_mismatch) begin
                r_fail_vec[r_idx] <= 1'b1;
                if (r_err_count != c_err_max) begin
                    r_err_count <= r_err_count + c_err_one;
                end
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
                r_fail_idx <= r_idx;
`endif
            end
            if (w_finish) begin
                r_pass <= (r_err_count == '0) && !w_mismatch;
            end
        end
    end

    assign bus.dut_in    = w_dut_in;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.pass      = r_pass;
    assign bus.fail_vec  = r_fail_vec;
    assign bus.err_count = r_err_count;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    assign bus.fail_idx  = r_fail_idx;
`endif

endmodule
`default_nettype wire
